lsu_mem_req_bridge: RTL and testbench

// Sits between the LSU data-request channel and the data port of the 2R1W

---
 rtl/lsu_mem_req_bridge.sv | 166 ++++++++++++++++
 tb/tb_lsu_mem_req_bridge.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_req_bridge.sv
// Single-outstanding bridge from the LSU request channel to the 2R1W data port:
// natural-alignment check, write strobes, 1-cycle read capture, tagged response.
module lsu_mem_req_bridge #(
    parameter int LSU_ADDR_WIDTH = 56,
    parameter int LSU_DATA_WIDTH = 64,
    parameter int TAG_WIDTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_is_store,
    input  logic [LSU_ADDR_WIDTH-1:0]   req_addr,
    input  logic [1:0]                  req_size,
    input  logic                        req_unsign,
    input  logic [LSU_DATA_WIDTH-1:0]   req_wdata,
    input  logic [TAG_WIDTH-1:0]        req_tag,
    output logic [LSU_DATA_WIDTH/8-1:0] mem_we,
    output logic [LSU_DATA_WIDTH-1:0]   mem_din,
    output logic [LSU_ADDR_WIDTH-1:0]   mem_waddr,
    output logic [LSU_ADDR_WIDTH-1:0]   mem_raddr,
    output logic [1:0]                  mem_rsize,
    output logic                        mem_unsign,
    input  logic [LSU_DATA_WIDTH-1:0]   mem_dout,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [LSU_DATA_WIDTH-1:0]   resp_data,
    output logic [TAG_WIDTH-1:0]        resp_tag,
    output logic                        resp_is_store,
    output logic                        resp_misalign
);

    localparam int STRB_W = LSU_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPT,
        RESP
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   req_misalign;

    logic                      is_store_p0;
    logic [LSU_ADDR_WIDTH-1:0] addr_p0;
    logic [1:0]                size_p0;
    logic                      unsign_p0;
    logic [LSU_DATA_WIDTH-1:0] wdata_p0;
    logic [TAG_WIDTH-1:0]      tag_p0;
    logic                      misalign_p0;
    logic [LSU_DATA_WIDTH-1:0] resp_data_p1;

    // Byte strobe covering 1 << size bytes, low-justified.
    function automatic logic [STRB_W-1:0] size_strobe(input logic [1:0] size);
        logic [STRB_W-1:0] strb;
        strb = '0;
        for (int i = 0; i < STRB_W; i++) begin
            if (i < (1 << size)) begin
                strb[i] = 1'b1;
            end
        end
        return strb;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo);
        logic mis;
        case (size)
            2'd1:    mis = lo[0];
            2'd2:    mis = |lo[1:0];
            2'd3:    mis = |lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    assign req_misalign = is_misaligned(req_size, req_addr[2:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        resp_valid = 1'b0;
        mem_we     = '0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                accept    = req_valid && !rst;
                if (accept) begin
                    state_nxt = req_misalign ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                // Reset landing on ISSUE must suppress the write outright.
                if (is_store_p0 && !rst) begin
                    mem_we = size_strobe(size_p0);
                end
                state_nxt = is_store_p0 ? RESP : CAPT;
            end
            CAPT: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // p0: request capture on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            is_store_p0 <= 1'b0;
            addr_p0     <= '0;
            size_p0     <= '0;
            unsign_p0   <= 1'b0;
            wdata_p0    <= '0;
            tag_p0      <= '0;
            misalign_p0 <= 1'b0;
        end else if (accept) begin
            is_store_p0 <= req_is_store;
            addr_p0     <= req_addr;
            size_p0     <= req_size;
            unsign_p0   <= req_unsign;
            wdata_p0    <= req_wdata;
            tag_p0      <= req_tag;
            misalign_p0 <= req_misalign;
        end
    end

    // p1: response data, cleared on accept so stores and errors return 0
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data_p1 <= '0;
        end else if (accept) begin
            resp_data_p1 <= '0;
        end else if (state == CAPT) begin
            resp_data_p1 <= mem_dout;
        end
    end

    assign mem_din       = wdata_p0;
    assign mem_waddr     = addr_p0;
    assign mem_raddr     = addr_p0;
    assign mem_rsize     = size_p0;
    assign mem_unsign    = unsign_p0;
    assign resp_data     = resp_data_p1;
    assign resp_tag      = tag_p0;
    assign resp_is_store = is_store_p0;
    assign resp_misalign = misalign_p0;

endmodule

// File: tb/tb_lsu_mem_req_bridge.sv
// Bench for lsu_mem_req_bridge: directed cases plus 200 random requests against
// a byte-array reference memory, with a registered-read memory model on the port.
module tb_lsu_mem_req_bridge;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [55:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsign;
    logic [63:0] req_wdata;
    logic [3:0]  req_tag;
    logic [7:0]  mem_we;
    logic [63:0] mem_din;
    logic [55:0] mem_waddr;
    logic [55:0] mem_raddr;
    logic [1:0]  mem_rsize;
    logic        mem_unsign;
    logic [63:0] mem_dout;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic [3:0]  resp_tag;
    logic        resp_is_store;
    logic        resp_misalign;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_count = 0;
    logic mem_clr;

    logic [7:0] bfm_mem [0:16383];
    logic [7:0] ref_mem [0:16383];

    logic [63:0] last_data;
    logic [7:0]  issue_we;
    logic [55:0] issue_waddr;
    logic [55:0] issue_raddr;
    logic [63:0] issue_din;

    lsu_mem_req_bridge #(
        .LSU_ADDR_WIDTH(56),
        .LSU_DATA_WIDTH(64),
        .TAG_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_is_store(req_is_store),
        .req_addr(req_addr),
        .req_size(req_size),
        .req_unsign(req_unsign),
        .req_wdata(req_wdata),
        .req_tag(req_tag),
        .mem_we(mem_we),
        .mem_din(mem_din),
        .mem_waddr(mem_waddr),
        .mem_raddr(mem_raddr),
        .mem_rsize(mem_rsize),
        .mem_unsign(mem_unsign),
        .mem_dout(mem_dout),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data(resp_data),
        .resp_tag(resp_tag),
        .resp_is_store(resp_is_store),
        .resp_misalign(resp_misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [13:0] idx(input logic [55:0] a, input int i);
        logic [55:0] s;
        s = a + 56'(i);
        return s[13:0];
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] v, input int nb, input logic un);
        logic [63:0] r;
        r = v;
        if (!un && nb < 8 && v[8*nb-1]) r = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*nb));
        return r;
    endfunction

    function automatic logic [63:0] bfm_read(input logic [55:0] a, input logic [1:0] sz, input logic un);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < (1 << sz); i++) v[8*i +: 8] = bfm_mem[idx(a, i)];
        return extend(v, 1 << sz, un);
    endfunction

    // Memory port model: registered extended read, byte-strobed write.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16384; i++) bfm_mem[i] <= 8'h00;
        end else begin
            mem_dout <= bfm_read(mem_raddr, mem_rsize, mem_unsign);
            if (mem_we != 8'h00) begin
                wr_count <= wr_count + 1;
                for (int i = 0; i < 8; i++)
                    if (mem_we[i]) bfm_mem[idx(mem_waddr, i)] <= mem_din[8*i +: 8];
            end
        end
    end

    function automatic logic [63:0] ref_load(input logic [55:0] a, input logic [1:0] sz, input logic un);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < (1 << sz); i++) v[8*i +: 8] = ref_mem[idx(a, i)];
        return extend(v, 1 << sz, un);
    endfunction

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    // One full transaction; starts and ends with the bridge idle, inputs driven near negedge.
    task automatic do_req(input logic st, input logic [55:0] a, input logic [1:0] sz,
                          input logic un, input logic [63:0] wd, input logic [3:0] tg,
                          input int hold, input string nm);
        logic        exp_mis;
        logic [7:0]  exp_we;
        logic [63:0] exp_data;
        int          exp_lat, exp_wr, nb, lat, wr0;
        nb       = 1 << sz;
        exp_mis  = (int'(a[15:0]) % nb) != 0;
        exp_lat  = exp_mis ? 1 : (st ? 2 : 3);
        exp_wr   = (st && !exp_mis) ? 1 : 0;
        exp_we   = (st && !exp_mis) ? 8'((1 << nb) - 1) : 8'h00;
        exp_data = 64'h0;
        if (!exp_mis && st) begin
            for (int i = 0; i < nb; i++) ref_mem[idx(a, i)] = wd[8*i +: 8];
        end else if (!exp_mis) begin
            exp_data = ref_load(a, sz, un);
        end

        req_is_store = st;
        req_addr     = a;
        req_size     = sz;
        req_unsign   = un;
        req_wdata    = wd;
        req_tag      = tg;
        req_valid    = 1'b1;
        resp_ready   = 1'b0;
        #1;
        check({nm, "_req_ready"}, 64'(req_ready), 64'd1);
        wr0 = wr_count;
        @(posedge clk);
        @(negedge clk);
        req_valid   = 1'b0;
        lat         = 1;
        issue_we    = mem_we;
        issue_waddr = mem_waddr;
        issue_raddr = mem_raddr;
        issue_din   = mem_din;
        check({nm, "_issue_we"}, 64'(mem_we), 64'(exp_we));
        check({nm, "_busy"}, 64'(req_ready), 64'd0);
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check({nm, "_tag"}, 64'(resp_tag), 64'(tg));
        check({nm, "_is_store"}, 64'(resp_is_store), 64'(st));
        check({nm, "_misalign"}, 64'(resp_misalign), 64'(exp_mis));
        check({nm, "_data"}, resp_data, exp_data);
        check({nm, "_writes"}, 64'(wr_count - wr0), 64'(exp_wr));
        last_data = resp_data;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({nm, "_hold_valid"}, 64'(resp_valid), 64'd1);
            check({nm, "_hold_data"}, resp_data, exp_data);
            check({nm, "_hold_tag"}, 64'(resp_tag), 64'(tg));
            check({nm, "_hold_ready"}, 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check({nm, "_done_valid"}, 64'(resp_valid), 64'd0);
        check({nm, "_done_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        int          wr0;
        logic [1:0]  sz;
        logic [55:0] a;
        int          off, nb;

        for (int i = 0; i < 16384; i++) ref_mem[i] = 8'h00;
        rst          = 1'b1;
        mem_clr      = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_addr     = '0;
        req_size     = '0;
        req_unsign   = 1'b0;
        req_wdata    = '0;
        req_tag      = '0;
        resp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_resp_tag", 64'(resp_tag), 64'd0);
        check("rst_resp_is_store", 64'(resp_is_store), 64'd0);
        check("rst_resp_misalign", 64'(resp_misalign), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_waddr", 64'(mem_waddr), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", 64'(req_ready), 64'd1);

        do_req(1'b1, 56'h1000, 2'd3, 1'b0, 64'h1122334455667788, 4'd3, 0, "st_d");
        check("st_d_we", 64'(issue_we), 64'hFF);
        check("st_d_waddr", 64'(issue_waddr), 64'h1000);
        check("st_d_din", issue_din, 64'h1122334455667788);

        do_req(1'b1, 56'h1005, 2'd0, 1'b0, 64'h00000000000000AB, 4'd1, 0, "st_b");
        do_req(1'b0, 56'h1005, 2'd0, 1'b1, 64'h0, 4'd2, 0, "ld_bu");
        check("ld_bu_value", last_data, 64'h00000000000000AB);
        check("ld_bu_raddr", 64'(issue_raddr), 64'h1005);
        do_req(1'b0, 56'h1005, 2'd0, 1'b0, 64'h0, 4'd4, 0, "ld_bs");
        check("ld_bs_value", last_data, 64'hFFFFFFFFFFFFFFAB);

        do_req(1'b0, 56'h1002, 2'd2, 1'b0, 64'h0, 4'd5, 0, "ld_w_mis");
        check("ld_w_mis_value", last_data, 64'h0);

        do_req(1'b0, 56'h1000, 2'd3, 1'b0, 64'h0, 4'd6, 5, "ld_d_hold");
        check("ld_d_hold_value", last_data, 64'h1122AB4455667788);

        do_req(1'b1, 56'h2000, 2'd1, 1'b0, 64'h0000000000001234, 4'd7, 0, "st_h_old");
        req_is_store = 1'b1;
        req_addr     = 56'h2000;
        req_size     = 2'd1;
        req_unsign   = 1'b0;
        req_wdata    = 64'h000000000000BEEF;
        req_tag      = 4'd8;
        req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check("rst_issue_we", 64'(mem_we), 64'd0);
        check("rst_issue_ready", 64'(req_ready), 64'd0);
        wr0 = wr_count;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_issue_no_resp", 64'(resp_valid), 64'd0);
        end
        check("rst_issue_no_write", 64'(wr_count - wr0), 64'd0);
        check("rst_issue_idle", 64'(req_ready), 64'd1);
        do_req(1'b0, 56'h2000, 2'd1, 1'b1, 64'h0, 4'd9, 0, "ld_h_old");
        check("ld_h_old_value", last_data, 64'h0000000000001234);

        for (int i = 0; i < 200; i++) begin
            sz  = 2'($urandom_range(0, 3));
            nb  = 1 << sz;
            off = $urandom_range(0, 63);
            if (i % 2 == 0) off = (off / nb) * nb;
            a = 56'h3000 + 56'(off);
            do_req(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)),
                   {$urandom(), $urandom()}, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 2), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
